// File: rtl/dvi_ddr_pixel_output.sv
// DVI DDR pixel output stage: pulls one 24-bit pixel per active pixel and
// emits it as two 12-bit halves on consecutive clocks, low half first.
// HSYNC/VSYNC/DE are registered with one cycle of latency. A sticky flag and
// a saturating counter report pixels the upstream source failed to supply.
module dvi_ddr_pixel_output #(
  parameter int   H_ACTIVE     = 24,
  parameter int   H_TOTAL      = 32,
  parameter int   V_ACTIVE     = 16,
  parameter int   V_TOTAL      = 24,
  parameter int   H_SYNC_START = 26,
  parameter int   H_SYNC_LEN   = 3,
  parameter int   V_SYNC_START = 18,
  parameter int   V_SYNC_LEN   = 2,
  parameter logic SYNC_POL     = 1'b0
) (
  input  logic                         iClk,
  input  logic                         iRstN,
  input  logic                         iPixelSub,
  input  logic [$clog2(H_TOTAL):0]     iHpixel,
  input  logic [$clog2(V_TOTAL):0]     iVpixel,
  input  logic                         iPixelActive,
  input  logic [23:0]                  iPixelData,
  input  logic                         iPixelValid,
  output logic                         oPixelReady,
  input  logic                         iClearUnderflow,
  output logic [11:0]                  oData,
  output logic                         oHsync,
  output logic                         oVsync,
  output logic                         oDe,
  output logic                         oUnderflow,
  output logic [15:0]                  oUnderflowCount
);

  // Elaboration-time sanity checks on the video timing parameters.
  if (H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL) begin : gBadActive
    $error("active area exceeds total frame size");
  end
  if (H_SYNC_START >= H_TOTAL || V_SYNC_START >= V_TOTAL) begin : gBadSync
    $error("sync start outside frame");
  end

  logic [11:0] hold;
  logic        accept;
  logic        starve;
  logic        hsyncNext;
  logic        vsyncNext;

  // True when idx lies in [start, start+len) taken modulo total; len 0 never matches.
  function automatic logic inWindow(input int idx, input int start,
                                    input int len, input int total);
    int d;
    d = idx - start;
    if (d < 0) d = d + total;
    return (len > 0) && (d < len);
  endfunction

  // One accept opportunity per active pixel, only on the first sub-phase.
  always_comb begin
    oPixelReady = !iPixelSub && iPixelActive && iRstN;
    accept      = oPixelReady && iPixelValid;
    starve      = oPixelReady && !iPixelValid;
  end

  // Sync windows evaluated on the incoming counters, registered below.
  always_comb begin
    hsyncNext = ~SYNC_POL;
    vsyncNext = ~SYNC_POL;
    if (inWindow(int'(iHpixel), H_SYNC_START, H_SYNC_LEN, H_TOTAL)) hsyncNext = SYNC_POL;
    if (inWindow(int'(iVpixel), V_SYNC_START, V_SYNC_LEN, V_TOTAL)) vsyncNext = SYNC_POL;
  end

  // Data path: low half on accept, stored high half on the following sub-phase.
  // A starved pixel clears hold so both halves of that pixel come out as zero.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oData <= '0;
      hold  <= '0;
    end else if (!iPixelActive) begin
      oData <= '0;
    end else if (!iPixelSub) begin
      if (accept) begin
        oData <= iPixelData[11:0];
        hold  <= iPixelData[23:12];
      end else begin
        oData <= '0;
        hold  <= '0;
      end
    end else begin
      oData <= hold;
    end
  end

  // Registered timing outputs.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oDe    <= 1'b0;
      oHsync <= ~SYNC_POL;
      oVsync <= ~SYNC_POL;
    end else begin
      oDe    <= iPixelActive;
      oHsync <= hsyncNext;
      oVsync <= vsyncNext;
    end
  end

  // Underflow flag and saturating counter; a starve coinciding with a clear wins.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oUnderflow      <= 1'b0;
      oUnderflowCount <= '0;
    end else if (starve) begin
      oUnderflow <= 1'b1;
      if (iClearUnderflow)             oUnderflowCount <= 16'd1;
      else if (oUnderflowCount != '1) oUnderflowCount <= oUnderflowCount + 16'd1;
    end else if (iClearUnderflow) begin
      oUnderflow      <= 1'b0;
      oUnderflowCount <= '0;
    end
  end

endmodule

// File: tb/tb_dvi_ddr_pixel_output.sv
// Directed testbench for dvi_ddr_pixel_output. A second instance with a
// sync window that crosses the end of line covers the wrap case.
module tb_dvi_ddr_pixel_output;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iPixelSub;
  logic [5:0]  iHpixel;
  logic [5:0]  iVpixel;
  logic        iPixelActive;
  logic [23:0] iPixelData;
  logic        iPixelValid;
  logic        iClearUnderflow;

  logic        oPixelReady;
  logic [11:0] oData;
  logic        oHsync, oVsync, oDe, oUnderflow;
  logic [15:0] oUnderflowCount;

  logic        wReady;
  logic [11:0] wData;
  logic        wHsync, wVsync, wDe, wUnderflow;
  logic [15:0] wUnderflowCount;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 iClk = ~iClk;

  dvi_ddr_pixel_output u_dut (
    .iClk(iClk), .iRstN(iRstN), .iPixelSub(iPixelSub), .iHpixel(iHpixel),
    .iVpixel(iVpixel), .iPixelActive(iPixelActive), .iPixelData(iPixelData),
    .iPixelValid(iPixelValid), .oPixelReady(oPixelReady),
    .iClearUnderflow(iClearUnderflow), .oData(oData), .oHsync(oHsync),
    .oVsync(oVsync), .oDe(oDe), .oUnderflow(oUnderflow),
    .oUnderflowCount(oUnderflowCount)
  );

  dvi_ddr_pixel_output #(.H_SYNC_START(30), .H_SYNC_LEN(4)) u_wrap (
    .iClk(iClk), .iRstN(iRstN), .iPixelSub(iPixelSub), .iHpixel(iHpixel),
    .iVpixel(iVpixel), .iPixelActive(iPixelActive), .iPixelData(iPixelData),
    .iPixelValid(iPixelValid), .oPixelReady(wReady),
    .iClearUnderflow(iClearUnderflow), .oData(wData), .oHsync(wHsync),
    .oVsync(wVsync), .oDe(wDe), .oUnderflow(wUnderflow),
    .oUnderflowCount(wUnderflowCount)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic sub, input int h, input int v,
                       input logic act, input logic vld, input logic [23:0] d);
    iPixelSub    = sub;
    iHpixel      = 6'(h);
    iVpixel      = 6'(v);
    iPixelActive = act;
    iPixelValid  = vld;
    iPixelData   = d;
  endtask

  task automatic test_reset();
    iRstN = 1'b0;
    iClearUnderflow = 1'b0;
    drive(1'b0, 27, 18, 1'b1, 1'b1, 24'hFFFFFF);
    cyc(); cyc();
    totalCnt++;
    if (oData !== 12'h000) $display("FAIL reset_data got %h want 000", oData); else passCnt++;
    totalCnt++;
    if ({oDe, oHsync, oVsync} !== 3'b011) $display("FAIL reset_sync got de/hs/vs=%b want 011", {oDe, oHsync, oVsync}); else passCnt++;
    totalCnt++;
    if ({oUnderflow, oUnderflowCount} !== 17'd0) $display("FAIL reset_underflow got %b/%0d want 0/0", oUnderflow, oUnderflowCount); else passCnt++;
    totalCnt++;
    if (oPixelReady !== 1'b0) $display("FAIL reset_ready got %b want 0", oPixelReady); else passCnt++;
    totalCnt++;
    if (wHsync !== 1'b1) $display("FAIL reset_wrap_hsync got %b want 1", wHsync); else passCnt++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 24'h0);
    cyc();
    iRstN = 1'b1;
    cyc();
  endtask

  task automatic test_single_pixel();
    drive(1'b0, 0, 0, 1'b1, 1'b1, 24'hABC123);
    #1;
    totalCnt++;
    if (oPixelReady !== 1'b1) $display("FAIL single_ready got %b want 1", oPixelReady); else passCnt++;
    cyc();
    totalCnt++;
    if ({oDe, oData} !== {1'b1, 12'h123}) $display("FAIL single_low got de=%b data=%h want de=1 data=123", oDe, oData); else passCnt++;
    drive(1'b1, 0, 0, 1'b1, 1'b0, 24'h0);
    #1;
    totalCnt++;
    if (oPixelReady !== 1'b0) $display("FAIL single_ready_sub1 got %b want 0", oPixelReady); else passCnt++;
    cyc();
    totalCnt++;
    if ({oDe, oData} !== {1'b1, 12'hABC}) $display("FAIL single_high got de=%b data=%h want de=1 data=ABC", oDe, oData); else passCnt++;
    drive(1'b0, 24, 0, 1'b0, 1'b1, 24'h0);
    #1;
    totalCnt++;
    if (oPixelReady !== 1'b0) $display("FAIL blank_ready got %b want 0", oPixelReady); else passCnt++;
    cyc();
    totalCnt++;
    if ({oDe, oData} !== {1'b0, 12'h000}) $display("FAIL blank_out got de=%b data=%h want de=0 data=000", oDe, oData); else passCnt++;
  endtask

  task automatic test_full_frame();
    int acc = 0, deCnt = 0, hsLow = 0, vsLow = 0;
    int dataErr = 0, hsErr = 0, vsErr = 0, wrapErr = 0, wrapLow = 0;
    logic [23:0] d;
    logic act, expHs, expVs, expWrap;
    logic [11:0] expData;
    for (int v = 0; v < 24; v++) begin
      for (int h = 0; h < 32; h++) begin
        d = {8'(h) + 8'h10, 8'(v) ^ 8'h3C, 8'(h) ^ 8'hA5};
        act = (h < 24) && (v < 16);
        expHs   = !(h == 26 || h == 27 || h == 28);
        expWrap = !(h == 30 || h == 31 || h == 0 || h == 1);
        expVs   = !(v == 18 || v == 19);
        for (int s = 0; s < 2; s++) begin
          drive(s[0], h, v, act, 1'b1, d);
          #1;
          if (oPixelReady && iPixelValid) acc++;
          expData = !act ? 12'h000 : (s == 0) ? d[11:0] : d[23:12];
          cyc();
          if (oDe) deCnt++;
          if (!oHsync) hsLow++;
          if (!oVsync) vsLow++;
          if (!wHsync) wrapLow++;
          if (oData !== expData) dataErr++;
          if (oHsync !== expHs) hsErr++;
          if (oVsync !== expVs) vsErr++;
          if (wHsync !== expWrap) wrapErr++;
        end
      end
    end
    totalCnt++;
    if (acc !== 384) $display("FAIL frame_accepts got %0d want 384", acc); else passCnt++;
    totalCnt++;
    if (deCnt !== 768) $display("FAIL frame_de_cycles got %0d want 768", deCnt); else passCnt++;
    totalCnt++;
    if (hsLow !== 144) $display("FAIL frame_hsync_low got %0d want 144", hsLow); else passCnt++;
    totalCnt++;
    if (vsLow !== 128) $display("FAIL frame_vsync_low got %0d want 128", vsLow); else passCnt++;
    totalCnt++;
    if (dataErr !== 0) $display("FAIL frame_data_errors got %0d want 0", dataErr); else passCnt++;
    totalCnt++;
    if (hsErr !== 0) $display("FAIL frame_hsync_position_errors got %0d want 0", hsErr); else passCnt++;
    totalCnt++;
    if (vsErr !== 0) $display("FAIL frame_vsync_position_errors got %0d want 0", vsErr); else passCnt++;
    totalCnt++;
    if (wrapLow !== 192) $display("FAIL wrap_hsync_low got %0d want 192", wrapLow); else passCnt++;
    totalCnt++;
    if (wrapErr !== 0) $display("FAIL wrap_hsync_position_errors got %0d want 0", wrapErr); else passCnt++;
    totalCnt++;
    if ({oUnderflow, oUnderflowCount} !== 17'd0) $display("FAIL frame_no_underflow got %b/%0d want 0/0", oUnderflow, oUnderflowCount); else passCnt++;
  endtask

  task automatic test_starvation();
    int badOut = 0;
    for (int p = 0; p < 5; p++) begin
      for (int s = 0; s < 2; s++) begin
        drive(s[0], p, 0, 1'b1, 1'b0, 24'h5A5A5A);
        cyc();
        if ({oDe, oData} !== {1'b1, 12'h000}) badOut++;
      end
    end
    totalCnt++;
    if (badOut !== 0) $display("FAIL starve_output got %0d bad cycles want 0", badOut); else passCnt++;
    totalCnt++;
    if ({oUnderflow, oUnderflowCount} !== {1'b1, 16'd5}) $display("FAIL starve_count got %b/%0d want 1/5", oUnderflow, oUnderflowCount); else passCnt++;
    drive(1'b0, 5, 0, 1'b1, 1'b0, 24'h0);
    iClearUnderflow = 1'b1;
    cyc();
    iClearUnderflow = 1'b0;
    totalCnt++;
    if ({oUnderflow, oUnderflowCount} !== {1'b1, 16'd1}) $display("FAIL starve_clear_collision got %b/%0d want 1/1", oUnderflow, oUnderflowCount); else passCnt++;
    drive(1'b1, 5, 0, 1'b1, 1'b0, 24'h0);
    iClearUnderflow = 1'b1;
    cyc();
    iClearUnderflow = 1'b0;
    totalCnt++;
    if ({oUnderflow, oUnderflowCount} !== 17'd0) $display("FAIL clear_only got %b/%0d want 0/0", oUnderflow, oUnderflowCount); else passCnt++;
  endtask

  task automatic test_midpixel_reset();
    drive(1'b0, 6, 0, 1'b1, 1'b1, 24'h777888);
    cyc();
    totalCnt++;
    if (oData !== 12'h888) $display("FAIL midrst_low got %h want 888", oData); else passCnt++;
    drive(1'b1, 6, 0, 1'b1, 1'b0, 24'h0);
    iRstN = 1'b0;
    #1;
    totalCnt++;
    if ({oData, oDe} !== 13'd0) $display("FAIL midrst_async got data=%h de=%b want 000/0", oData, oDe); else passCnt++;
    cyc();
    iRstN = 1'b1;
    drive(1'b1, 6, 0, 1'b1, 1'b0, 24'h0);
    cyc();
    totalCnt++;
    if ({oDe, oData} !== {1'b1, 12'h000}) $display("FAIL midrst_hold got de=%b data=%h want de=1 data=000", oDe, oData); else passCnt++;
    totalCnt++;
    if ({oUnderflow, oUnderflowCount} !== 17'd0) $display("FAIL midrst_underflow got %b/%0d want 0/0", oUnderflow, oUnderflowCount); else passCnt++;
    drive(1'b0, 7, 0, 1'b1, 1'b1, 24'h13579B);
    cyc();
    drive(1'b1, 7, 0, 1'b1, 1'b0, 24'h0);
    cyc();
    totalCnt++;
    if (oData !== 12'h135) $display("FAIL midrst_next_pixel got %h want 135", oData); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_starvation();
    test_midpixel_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
